// File: rtl/prod_pkg.sv
// Shared definitions for the 96-bit product path (width, beat count, beat-width legality).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prod_pkg;

  localparam int PROD_W = 96;

  // Number of OUT_W-bit beats needed to carry one product.
  function automatic int beats(input int out_w);
    return PROD_W / out_w;
  endfunction

  // Beat widths that divide the product evenly and are supported downstream.
  function automatic bit out_w_legal(input int out_w);
    return (out_w == 8) || (out_w == 16) || (out_w == 32) || (out_w == 48);
  endfunction

endpackage

// File: rtl/prod_fifo.sv
// Synchronous DEPTH x W register FIFO holding whole products.
// Latency: a push is visible at head_o / count_o the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module prod_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/prod_serializer.sv
// Buffers 96-bit multiplier products and emits them as OUT_W-bit beats, MS beat first.
// Latency: first beat valid 1 cycle after the push into an empty FIFO; 1 beat/cycle when ready.
// Backpressure: out_ready stalls beats; upstream cannot stall, so a push into a full FIFO is dropped and flagged sticky.
module prod_serializer
  import prod_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [PROD_W-1:0]          in_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int BEATS = beats(OUT_W);
  localparam int BW    = $clog2(BEATS);

  if (!out_w_legal(OUT_W)) begin : g_bad_out_w
    $error("prod_serializer: OUT_W must be 8, 16, 32 or 48");
  end

  logic [PROD_W-1:0] head;
  logic [PROD_W-1:0] head_shifted;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              beat_end;
  logic              pop;
  logic [BW-1:0]     beat_q, beat_d;
  logic              overflow_q, overflow_d;

  prod_fifo #(
    .DEPTH(DEPTH),
    .W    (PROD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (in_valid),
    .push_data_i(in_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign beat_end  = (beat_q == BW'(BEATS-1));
  assign out_last  = out_valid && beat_end;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && beat_end;
  assign overflow  = overflow_q;

  // Beat select: move the current beat to the top of the word, then take the top OUT_W bits.
  always_comb begin
    head_shifted = head << (int'(beat_q) * OUT_W);
    out_data     = '0;
    if (out_valid) out_data = head_shifted[PROD_W-1 -: OUT_W];
  end

  // Beat advance on each transfer; overflow latches any product the full FIFO refused.
  always_comb begin
    beat_d     = beat_q;
    overflow_d = overflow_q;
    if (xfer) beat_d = beat_end ? '0 : beat_q + 1'b1;
    if (in_valid && fifo_full && !pop) overflow_d = 1'b1;
  end

  // Beat counter and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_prod_serializer.sv
// Self-checking bench: queue-based product model for the default instance, plus a directed OUT_W=48 instance.
// Latency: n/a (testbench).
// Backpressure: out_ready driven from directed patterns and $urandom.
module tb_prod_serializer;
  import prod_pkg::*;

  localparam int DEPTH = 4;
  localparam int OUT_W = 16;
  localparam int BEATS = PROD_W / OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic [95:0]       in_data;
  logic              out_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              overflow;
  logic [2:0]        count;

  logic              v48;
  logic [95:0]       d48;
  logic              r48;
  logic              o48_valid;
  logic [47:0]       o48_data;
  logic              o48_last;
  logic              o48_ovf;
  logic [2:0]        o48_count;

  prod_serializer #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .overflow(overflow), .count(count)
  );

  prod_serializer #(.DEPTH(4), .OUT_W(48)) u_dut48 (
    .clk(clk), .rst(rst), .in_valid(v48), .in_data(d48), .out_ready(r48),
    .out_valid(o48_valid), .out_data(o48_data), .out_last(o48_last), .overflow(o48_ovf), .count(o48_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of whole products, the index of the beat on offer, and the sticky drop flag.
  logic [95:0] mq[$];
  int          mbeat = 0;
  bit          movf  = 1'b0;
  logic [95:0] got[$];

  // One clock: compare DUT outputs with the model, drive inputs, advance the model past the next edge.
  task automatic cycle(input bit v, input logic [95:0] d, input bit r, input bit rs);
    logic [95:0] sh;
    bit ev, xfer, pop;
    int sz;
    @(negedge clk);
    ev = (mq.size() != 0);
    sh = ev ? (mq[0] >> ((BEATS-1-mbeat) * OUT_W)) : 96'd0;
    check("out_valid", 96'(out_valid), 96'(ev));
    check("out_data",  96'(out_data),  96'(sh[OUT_W-1:0]));
    check("out_last",  96'(out_last),  96'(ev && (mbeat == BEATS-1)));
    check("count",     96'(count),     96'(mq.size()));
    check("overflow",  96'(overflow),  96'(movf));
    rst       = rs;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    if (rs) begin
      mq.delete();
      mbeat = 0;
      movf  = 1'b0;
    end else begin
      sz   = mq.size();
      xfer = ev && r;
      pop  = xfer && (mbeat == BEATS-1);
      if (xfer) begin
        got.push_back(96'(out_data));
        if (pop) begin
          void'(mq.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (v) begin
        if (sz < DEPTH || pop) mq.push_back(d);
        else movf = 1'b1;
      end
    end
  endtask

  logic [95:0] prod_a;
  logic [15:0] exp_a [6];
  bit          bp_pat [9];

  initial begin
    prod_a = 96'h0123_4567_89AB_CDEF_0011_2233;
    exp_a  = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0011, 16'h2233};
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    v48 = 1'b0; d48 = '0; r48 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, then a single product drained at full rate.
    cycle(0, '0, 0, 1);
    got.delete();
    cycle(1, prod_a, 1, 0);
    repeat (8) cycle(0, '0, 1, 0);
    check("single_nbeats", 96'(got.size()), 96'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("single_beat", got[i], 96'(exp_a[i]));

    // Backpressure pattern on the same product.
    got.delete();
    cycle(1, prod_a, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, '0, bp_pat[i], 0);
    cycle(0, '0, 0, 0);
    check("bp_nbeats", 96'(got.size()), 96'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("bp_beat", got[i], 96'(exp_a[i]));

    // Overflow: five pushes into a stalled FIFO, then drain.
    for (int i = 1; i <= 5; i++) cycle(1, 96'(i), 0, 0);
    cycle(0, '0, 0, 0);
    check("ovf_count", 96'(count), 96'd4);
    check("ovf_flag", 96'(overflow), 96'd1);
    got.delete();
    repeat (26) cycle(0, '0, 1, 0);
    check("ovf_nbeats", 96'(got.size()), 96'd24);
    if (got.size() == 24) begin
      check("ovf_first_prod", got[5], 96'd1);
      check("ovf_last_prod", got[23], 96'd4);
    end
    check("ovf_sticky", 96'(overflow), 96'd1);

    // Full FIFO accepts a push in the cycle its head's final beat leaves.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 96'(16 + i), 0, 0);
    got.delete();
    repeat (5) cycle(0, '0, 1, 0);
    cycle(1, {12{8'hAA}}, 1, 0);
    cycle(0, '0, 1, 0);
    check("fullpop_count", 96'(count), 96'd4);
    repeat (26) cycle(0, '0, 1, 0);
    check("fullpop_ovf", 96'(overflow), 96'd0);
    if (got.size() > 0) check("fullpop_tail", got[got.size()-1], 96'hAAAA);
    check("fullpop_nbeats", 96'(got.size()), 96'd30);

    // Reset during beat 3 with two products queued behind the head.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 96'(32 + i), 0, 0);
    repeat (3) cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 0);
    check("rst_count", 96'(count), 96'd0);
    check("rst_data", 96'(out_data), 96'd0);
    got.delete();
    cycle(1, prod_a, 1, 0);
    repeat (7) cycle(0, '0, 1, 0);
    if (got.size() > 0) check("rst_restart_beat0", got[0], 96'h0123);

    // Randomized traffic with varying push density and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit v, r, rs;
      rs = ($urandom_range(0, 299) == 0);
      v  = (i % 600 < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      r  = ($urandom_range(0, 3) != 0);
      cycle(v, {$urandom, $urandom, $urandom}, r, rs);
    end
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);

    // OUT_W=48 instance: two beats per product, back-to-back products with no bubble.
    @(negedge clk);
    v48 = 1'b1; d48 = 96'hFFFF_0000_1234_5678_9ABC_DEF0; r48 = 1'b0;
    @(negedge clk);
    check("w48_b0_valid", 96'(o48_valid), 96'd1);
    check("w48_b0_data", 96'(o48_data), 96'hFFFF_0000_1234);
    check("w48_b0_last", 96'(o48_last), 96'd0);
    v48 = 1'b1; d48 = 96'h1111_2222_3333_4444_5555_6666; r48 = 1'b1;
    @(negedge clk);
    v48 = 1'b0;
    check("w48_b1_data", 96'(o48_data), 96'h5678_9ABC_DEF0);
    check("w48_b1_last", 96'(o48_last), 96'd1);
    check("w48_count2", 96'(o48_count), 96'd2);
    @(negedge clk);
    check("w48_p2_valid", 96'(o48_valid), 96'd1);
    check("w48_p2_b0", 96'(o48_data), 96'h1111_2222_3333);
    check("w48_count1", 96'(o48_count), 96'd1);
    @(negedge clk);
    check("w48_p2_b1", 96'(o48_data), 96'h4444_5555_6666);
    check("w48_p2_last", 96'(o48_last), 96'd1);
    @(negedge clk);
    r48 = 1'b0;
    check("w48_idle_valid", 96'(o48_valid), 96'd0);
    check("w48_idle_count", 96'(o48_count), 96'd0);
    check("w48_ovf", 96'(o48_ovf), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
